// File: rtl/hockey_pkg.sv
// Shared constants and types for the hockey display: grid limits, turn codes,
// active-low seven-segment patterns and the scan FSM state encoding.
package hockey_pkg;

    localparam int COORD_W = 3;
    localparam int SCORE_W = 3;
    localparam logic [COORD_W-1:0] GRID_MAX = 3'd4;

    localparam logic [1:0] TURN_IDLE = 2'd0;
    localparam logic [1:0] TURN_A    = 2'd1;
    localparam logic [1:0] TURN_B    = 2'd2;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_D0    = 7'b1000000;
    localparam logic [6:0] SEG_D1    = 7'b1111001;
    localparam logic [6:0] SEG_D2    = 7'b0100100;
    localparam logic [6:0] SEG_D3    = 7'b0110000;
    localparam logic [6:0] SEG_D4    = 7'b0011001;
    localparam logic [6:0] SEG_D5    = 7'b0010010;
    localparam logic [6:0] SEG_D6    = 7'b0000010;
    localparam logic [6:0] SEG_D7    = 7'b1111000;
    localparam logic [6:0] SEG_D8    = 7'b0000000;
    localparam logic [6:0] SEG_D9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_PUCK_Y0 = 7'b1111110;
    localparam logic [6:0] SEG_PUCK_Y1 = 7'b1011101;
    localparam logic [6:0] SEG_PUCK_Y2 = 7'b0111111;
    localparam logic [6:0] SEG_PUCK_Y3 = 7'b1101011;
    localparam logic [6:0] SEG_PUCK_Y4 = 7'b1110111;

    // Encoder code that selects the dash separator
    localparam logic [3:0] CODE_DASH = 4'd10;

    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SCORE_W-1:0] score_a;
        logic [SCORE_W-1:0] score_b;
        logic [1:0]         turn;
        logic               end_game;
    } frame_s;

    function automatic logic [6:0] puck_pattern(input logic [COORD_W-1:0] y);
        logic [6:0] pat;
        case (y)
            3'd0:    pat = SEG_PUCK_Y0;
            3'd1:    pat = SEG_PUCK_Y1;
            3'd2:    pat = SEG_PUCK_Y2;
            3'd3:    pat = SEG_PUCK_Y3;
            3'd4:    pat = SEG_PUCK_Y4;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/hockey_display_seg7_encode.sv
// Combinational decimal/dash encoder producing active-low segment drive.
module seg7_encode
    import hockey_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Value-to-pattern lookup with blank override
    always_comb begin
        seg_o = SEG_BLANK;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (value_i)
                4'd0:      seg_o = SEG_D0;
                4'd1:      seg_o = SEG_D1;
                4'd2:      seg_o = SEG_D2;
                4'd3:      seg_o = SEG_D3;
                4'd4:      seg_o = SEG_D4;
                4'd5:      seg_o = SEG_D5;
                4'd6:      seg_o = SEG_D6;
                4'd7:      seg_o = SEG_D7;
                4'd8:      seg_o = SEG_D8;
                4'd9:      seg_o = SEG_D9;
                CODE_DASH: seg_o = SEG_DASH;
                default:   seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/hockey_display.sv
// Renders puck position, scores and turn state onto an 8-digit multiplexed
// seven-segment display; inputs are snapshotted once per scan frame.
module hockey_display
    import hockey_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coord_valid,
    input  logic [2:0] x_coord,
    input  logic [2:0] y_coord,
    input  logic [2:0] score_a,
    input  logic [2:0] score_b,
    input  logic [1:0] turn,
    input  logic       end_game,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       led_a,
    output logic       led_b,
    output logic [4:0] led_x
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 2);
    localparam logic [SCAN_W-1:0]  SCAN_ONE   = SCAN_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    scan_state_e          state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_q, blink_d;
    frame_s               pend_q, pend_d;
    frame_s               disp_q, disp_d;

    logic [7:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 led_a_q, led_a_d;
    logic                 led_b_q, led_b_d;
    logic [4:0]           led_x_q, led_x_d;

    logic                 puck_on_s;
    logic                 puck_here_s;
    logic [2:0]           rink_col_s;
    logic [3:0]           enc_value_s;
    logic                 enc_blank_s;
    logic [6:0]           enc_seg_s;

    // State, snapshot and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_SHOW;
            idx_q       <= 3'd0;
            scan_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            pend_q      <= '0;
            disp_q      <= '0;
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            led_a_q     <= 1'b0;
            led_b_q     <= 1'b0;
            led_x_q     <= 5'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            scan_cnt_q  <= scan_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            pend_q      <= pend_d;
            disp_q      <= disp_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            led_a_q     <= led_a_d;
            led_b_q     <= led_b_d;
            led_x_q     <= led_x_d;
        end
    end

    // Scan FSM, frame-boundary snapshot and blink phase
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        scan_cnt_d  = scan_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        disp_d      = disp_q;
        pend_d      = pend_q;

        if (coord_valid) begin
            pend_d.x        = x_coord;
            pend_d.y        = y_coord;
            pend_d.score_a  = score_a;
            pend_d.score_b  = score_b;
            pend_d.turn     = turn;
            pend_d.end_game = end_game;
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            ST_SHOW: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    state_d    = ST_GAP;
                    scan_cnt_d = '0;
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_ONE;
                end
            end
            ST_GAP: begin
                state_d = ST_SHOW;
                idx_d   = idx_q + 3'd1;
                // Old pending is loaded here; a same-cycle capture waits a frame
                if (idx_q == 3'd7) begin
                    disp_d = pend_q;
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_ONE;
                    end
                end else begin
                    disp_d = disp_q;
                end
            end
            default: begin
                state_d    = ST_SHOW;
                scan_cnt_d = '0;
            end
        endcase
    end

    // Digit content selection for the score side
    always_comb begin
        enc_value_s = 4'd0;
        enc_blank_s = 1'b1;
        case (idx_q)
            3'd7: begin
                enc_value_s = {1'b0, disp_q.score_a};
                enc_blank_s = disp_q.end_game && (disp_q.score_a == 3'd3) && blink_q;
            end
            3'd6: begin
                enc_value_s = CODE_DASH;
                enc_blank_s = 1'b0;
            end
            3'd5: begin
                enc_value_s = {1'b0, disp_q.score_b};
                enc_blank_s = disp_q.end_game && (disp_q.score_b == 3'd3) && blink_q;
            end
            default: begin
                enc_value_s = 4'd0;
                enc_blank_s = 1'b1;
            end
        endcase
    end

    seg7_encode u_seg7_encode (
        .value_i (enc_value_s),
        .blank_i (enc_blank_s),
        .seg_o   (enc_seg_s)
    );

    // Next values of the registered display outputs
    always_comb begin
        puck_on_s   = (disp_q.turn != TURN_IDLE) && !disp_q.end_game &&
                      (disp_q.x <= GRID_MAX) && (disp_q.y <= GRID_MAX);
        rink_col_s  = GRID_MAX - idx_q;
        puck_here_s = puck_on_s && (idx_q <= GRID_MAX) && (disp_q.x == rink_col_s);

        an_d    = 8'hFF;
        seg_d   = SEG_BLANK;
        if (state_q == ST_GAP) begin
            an_d  = 8'hFF;
            seg_d = SEG_BLANK;
        end else begin
            an_d = ~(8'd1 << idx_q);
            if (idx_q > GRID_MAX) begin
                seg_d = enc_seg_s;
            end else if (puck_here_s) begin
                seg_d = puck_pattern(disp_q.y);
            end else begin
                seg_d = SEG_BLANK;
            end
        end

        led_a_d = (disp_q.turn == TURN_A) && !disp_q.end_game;
        led_b_d = (disp_q.turn == TURN_B) && !disp_q.end_game;
        if (puck_on_s) begin
            led_x_d = 5'd1 << disp_q.x;
        end else begin
            led_x_d = 5'd0;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign led_a = led_a_q;
    assign led_b = led_b_q;
    assign led_x = led_x_q;

endmodule

// File: tb/tb_hockey_display.sv
// Directed scoreboard bench for hockey_display with a short scan and blink period.
module tb_hockey_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coord_valid = 1'b0;
    logic [2:0] x_coord = 3'd0, y_coord = 3'd0, score_a = 3'd0, score_b = 3'd0;
    logic [1:0] turn = 2'd0;
    logic       end_game = 1'b0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       led_a, led_b;
    logic [4:0] led_x;

    always #5 clk = ~clk;

    hockey_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .rst(rst), .coord_valid(coord_valid),
        .x_coord(x_coord), .y_coord(y_coord), .score_a(score_a), .score_b(score_b),
        .turn(turn), .end_game(end_game),
        .an(an), .seg(seg), .led_a(led_a), .led_b(led_b), .led_x(led_x)
    );

    typedef struct {
        string      tag;
        int         digit;
        logic [6:0] seg;
        logic [6:0] leds;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Frames started since reset release, used to predict the blink phase
    int         frame_cnt;
    logic [7:0] prev_an;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= -1;
            prev_an   <= 8'hFF;
        end else begin
            if (an == 8'hFE && prev_an != 8'hFE) frame_cnt <= frame_cnt + 1;
            prev_an <= an;
        end
    end

    function automatic logic [6:0] dig(input int d);
        logic [6:0] hi;
        case (d)
            0: hi = 7'b0111111;  1: hi = 7'b0000110;  2: hi = 7'b1011011;
            3: hi = 7'b1001111;  4: hi = 7'b1100110;  5: hi = 7'b1101101;
            6: hi = 7'b1111101;  7: hi = 7'b0000111;
            default: hi = 7'b0000000;
        endcase
        return ~hi;
    endfunction

    function automatic logic [6:0] puck(input int y);
        logic [6:0] hi;
        case (y)
            0: hi = 7'b0000001;  1: hi = 7'b0100010;  2: hi = 7'b1000000;
            3: hi = 7'b0010100;  4: hi = 7'b0001000;
            default: hi = 7'b0000000;
        endcase
        return ~hi;
    endfunction

    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'b0111111;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic wait_an(input logic [7:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (an === target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_an_not(input logic [7:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (an !== target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push(input string tag, input int d, input logic [6:0] s, input logic [6:0] l);
        exp_t e;
        e.tag = tag; e.digit = d; e.seg = s; e.leds = l;
        sb_q.push_back(e);
    endtask

    task automatic run_checks();
        exp_t e;
        bit   ok;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            wait_an(~(8'd1 << e.digit), ok);
            check({e.tag, "_found"}, {7'd0, ok}, 8'd1);
            if (ok) begin
                check({e.tag, "_seg"}, {1'b0, seg}, {1'b0, e.seg});
                check({e.tag, "_leds"}, {1'b0, led_a, led_b, led_x}, {1'b0, e.leds});
            end
        end
    endtask

    task automatic sync_frame();
        bit ok;
        wait_an_not(8'hFE, ok);
        check("leave_d0", {7'd0, ok}, 8'd1);
        wait_an(8'hFE, ok);
        check("frame_start", {7'd0, ok}, 8'd1);
    endtask

    task automatic apply(input logic [2:0] x, input logic [2:0] y, input logic [2:0] sa,
                         input logic [2:0] sb, input logic [1:0] t, input logic eg);
        bit ok;
        wait_an(8'hFE, ok);
        check("apply_sync", {7'd0, ok}, 8'd1);
        x_coord = x; y_coord = y; score_a = sa; score_b = sb; turn = t; end_game = eg;
        coord_valid = 1'b1;
        @(negedge clk);
        coord_valid = 1'b0;
        sync_frame();
    endtask

    initial begin
        int phase;
        // Reset hold
        repeat (3) @(negedge clk);
        check("rst_an", an, 8'hFF);
        check("rst_seg", {1'b0, seg}, 8'h7F);
        check("rst_leds", {1'b0, led_a, led_b, led_x}, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        check("first_an", an, 8'hFE);
        check("first_seg", {1'b0, seg}, 8'h7F);
        push("r_d0", 0, BLANK, 7'd0);
        push("r_d5", 5, dig(0), 7'd0);
        push("r_d6", 6, DASH, 7'd0);
        push("r_d7", 7, dig(0), 7'd0);
        run_checks();

        // Puck at x=2, y=0, player A to move
        apply(3'd2, 3'd0, 3'd1, 3'd2, 2'd1, 1'b0);
        push("b_d0", 0, BLANK, 7'b1000100);
        push("b_d1", 1, BLANK, 7'b1000100);
        push("b_d2", 2, puck(0), 7'b1000100);
        push("b_d3", 3, BLANK, 7'b1000100);
        push("b_d5", 5, dig(2), 7'b1000100);
        push("b_d6", 6, DASH, 7'b1000100);
        push("b_d7", 7, dig(1), 7'b1000100);
        run_checks();

        // Row patterns in column 0 (digit 4)
        for (int y = 0; y < 5; y++) begin
            apply(3'd0, 3'(y), 3'd1, 3'd2, 2'd1, 1'b0);
            push($sformatf("c_y%0d_d3", y), 3, BLANK, 7'b1000001);
            push($sformatf("c_y%0d_d4", y), 4, puck(y), 7'b1000001);
            run_checks();
        end

        // Off-grid column, player B
        apply(3'd5, 3'd0, 3'd1, 3'd2, 2'd2, 1'b0);
        for (int d = 0; d < 5; d++) push($sformatf("d_d%0d", d), d, BLANK, 7'b0100000);
        push("d_d5", 5, dig(2), 7'b0100000);
        push("d_d7", 7, dig(1), 7'b0100000);
        run_checks();

        // Game over, B wins: digit 5 blinks on frame-count phase
        apply(3'd1, 3'd1, 3'd1, 3'd3, 2'd2, 1'b1);
        for (int f = 0; f < 6; f++) begin
            @(negedge clk);
            phase = (frame_cnt / BLINK_DIV) % 2;
            push($sformatf("e_f%0d_d3", f), 3, BLANK, 7'd0);
            push($sformatf("e_f%0d_d5", f), 5, (phase == 1) ? BLANK : dig(3), 7'd0);
            push($sformatf("e_f%0d_d7", f), 7, dig(1), 7'd0);
            run_checks();
            sync_frame();
        end

        // Reset during SHOW of digit 5
        begin
            bit ok;
            wait_an(8'hDF, ok);
            check("f_sync_d5", {7'd0, ok}, 8'd1);
        end
        rst = 1'b0;
        #1;
        check("mid_rst_an", an, 8'hFF);
        check("mid_rst_seg", {1'b0, seg}, 8'h7F);
        check("mid_rst_leds", {1'b0, led_a, led_b, led_x}, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("restart_an", an, 8'hFE);
        push("f_d0", 0, BLANK, 7'd0);
        push("f_d4", 4, BLANK, 7'd0);
        push("f_d5", 5, dig(0), 7'd0);
        push("f_d6", 6, DASH, 7'd0);
        push("f_d7", 7, dig(0), 7'd0);
        run_checks();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
